// File: rtl/prime_pkg.sv
// Shared types and constants for the prime-test scheduler and its test engine.
package prime_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEST = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // 6k+-1 trial division: first divisor pair is (5, 7), then step by 6.
  localparam int unsigned FIRST_DIV = 5;
  localparam int unsigned DIV_STEP  = 6;

  // Increment modulo n, used for the round-robin pointer.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/prime_test_unit.sv
// Iterative primality engine: one screen cycle, then one 6k+-1 divisor pair per cycle.
// Pulses done for one cycle with the verdict on is_prime; abort drops the test silently.
module prime_test_unit
  import prime_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic             abort,
  output logic             done,
  output logic             is_prime
);

  logic             r_active;
  logic             r_screen;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_d;

  logic             w_screen_hit;
  logic             w_screen_prime;
  logic             w_loop_hit;
  logic             w_loop_prime;
  logic [2*WIDTH-1:0] w_dd;
  logic [WIDTH:0]     w_d2;
  logic [WIDTH:0]     w_n_ext;

  // Widened divisor arithmetic: d*d in 2*WIDTH bits and d+2 in WIDTH+1 bits never wrap.
  assign w_dd    = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};
  assign w_d2    = {1'b0, r_d} + (WIDTH + 1)'(2);
  assign w_n_ext = {1'b0, r_n};

  // Screen step: small values and multiples of 2 or 3 are decided in the first cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_screen_hit   = 1'b1;
    w_screen_prime = 1'b0;
    if (r_n <= WIDTH'(1)) begin
      w_screen_prime = 1'b0;
    end else if (r_n == WIDTH'(2) || r_n == WIDTH'(3)) begin
      w_screen_prime = 1'b1;
    end else if (!r_n[0] || (r_n % WIDTH'(3)) == '0) begin
      w_screen_prime = 1'b0;
    end else begin
      w_screen_hit = 1'b0;
    end
  end

  // Loop step: stop as prime once d*d exceeds n, or as composite on a divisor hit.
  always_comb begin
    w_loop_hit   = 1'b0;
    w_loop_prime = 1'b0;
    if (w_dd > {{WIDTH{1'b0}}, r_n}) begin
      w_loop_hit   = 1'b1;
      w_loop_prime = 1'b1;
    end else if ((r_n % r_d) == '0 || (w_n_ext % w_d2) == '0) begin
      w_loop_hit   = 1'b1;
      w_loop_prime = 1'b0;
    end
  end

  assign done     = r_active && (r_screen ? w_screen_hit : w_loop_hit);
  assign is_prime = r_screen ? w_screen_prime : w_loop_prime;

  // Engine state: load on start, advance the divisor each undecided cycle, clear on finish/abort.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_active <= 1'b0;
      r_screen <= 1'b0;
      r_n      <= '0;
      r_d      <= WIDTH'(FIRST_DIV);
    end else if (abort) begin
      r_active <= 1'b0;
    end else if (start) begin
      r_active <= 1'b1;
      r_screen <= 1'b1;
      r_n      <= num;
    end else if (r_active) begin
      if (done) begin
        r_active <= 1'b0;
      end else begin
        r_screen <= 1'b0;
        r_d      <= r_screen ? WIDTH'(FIRST_DIV) : r_d + WIDTH'(DIV_STEP);
      end
    end
  end

endmodule

// File: rtl/prime_test_scheduler.sv
// Round-robin front end sharing one prime_test_unit between NUM_REQ requesters.
// One test in flight; the result returns as a one-cycle pulse to the owning requester.
module prime_test_scheduler
  import prime_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_num,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     flush,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_num,
  output logic                     rsp_is_prime,
  output logic                     busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_id;
  logic [WIDTH-1:0]   r_num;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_num;
  logic               r_rsp_is_prime;

  logic [PTR_W:0]     w_pick;
  logic               w_grant_found;
  logic [PTR_W-1:0]   w_grant_id;
  logic               w_accept;
  logic [WIDTH-1:0]   w_cand;
  logic               w_abort;
  logic               w_unit_done;
  logic               w_unit_prime;

  // First valid requester scanning ptr, ptr+1, ... mod NUM_REQ; returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0]   pick;
    logic [PTR_W-1:0] idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  assign w_pick        = rr_pick(req_valid, r_rr_ptr);
  assign w_grant_found = w_pick[PTR_W];
  assign w_grant_id    = w_pick[PTR_W-1:0];
  assign w_accept      = reset_n && (r_state == S_IDLE) && w_grant_found;
  assign w_cand        = req_num[int'(w_grant_id)*WIDTH +: WIDTH];
  assign w_abort       = flush && (r_state != S_IDLE);

  assign req_ready     = w_accept ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign busy          = (r_state != S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_num       = r_rsp_num;
  assign rsp_is_prime  = r_rsp_is_prime;

  prime_test_unit #(
    .WIDTH(WIDTH)
  ) u_unit (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_accept),
    .num     (w_cand),
    .abort   (w_abort),
    .done    (w_unit_done),
    .is_prime(w_unit_prime)
  );

  // Next state: accept in IDLE, wait for the engine (or a flush) in TEST, one cycle in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_TEST;
      S_TEST: begin
        if (flush)            w_state_nxt = S_IDLE;
        else if (w_unit_done) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Accept bookkeeping: candidate, owner id and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_num    <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= PTR_W'(wrap_inc(int'(w_grant_id), NUM_REQ));
      r_id     <= w_grant_id;
      r_num    <= w_cand;
    end
  end

  // Response registers: pulse rsp_valid for the DONE cycle, hold number/verdict until the next result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_valid    <= '0;
      r_rsp_num      <= '0;
      r_rsp_is_prime <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (r_state == S_TEST && !flush && w_unit_done) begin
        r_rsp_valid    <= NUM_REQ'(1) << r_id;
        r_rsp_num      <= r_num;
        r_rsp_is_prime <= w_unit_prime;
      end
    end
  end

endmodule

// File: tb/tb_prime_test_scheduler.sv
// Directed bench for prime_test_scheduler: table of single-requester vectors plus
// hand-written arbitration, flush and mid-test reset sequences.
module tb_prime_test_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_num;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     flush;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_num;
  logic                     rsp_is_prime;
  logic                     busy;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [WIDTH-1:0] num;
    logic             is_prime;
    int               lat;     // cycles from accept edge to the rsp_valid cycle (2 + loop cycles)
  } vec_t;

  vec_t vecs[12];

  prime_test_scheduler #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_num     (req_num),
    .req_ready   (req_ready),
    .flush       (flush),
    .rsp_valid   (rsp_valid),
    .rsp_num     (rsp_num),
    .rsp_is_prime(rsp_is_prime),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_num(input int i, input logic [WIDTH-1:0] v);
    req_num[i*WIDTH +: WIDTH] = v;
  endtask

  // Called at posedge+1 right after the accept edge; waits for and checks the response.
  task automatic wait_rsp(input string name, input logic [NUM_REQ-1:0] exp_grant,
                          input logic [WIDTH-1:0] exp_num, input logic exp_prime, input int exp_lat);
    int lat;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (rsp_valid != '0) begin
        lat = c;
        break;
      end
      tick();
    end
    check({name, "_latency"},   lat,          exp_lat);
    check({name, "_rsp_valid"}, rsp_valid,    exp_grant);
    check({name, "_rsp_num"},   rsp_num,      exp_num);
    check({name, "_is_prime"},  rsp_is_prime, exp_prime);
    check({name, "_busy_done"}, busy,         1);
    tick();
    #1;
    check({name, "_pulse_end"}, rsp_valid,    0);
    check({name, "_idle"},      busy,         0);
    check({name, "_num_held"},  rsp_num,      exp_num);
  endtask

  // Called in an IDLE cycle with inputs driven: checks the grant, takes the accept edge, waits.
  task automatic run_one(input string name, input logic [NUM_REQ-1:0] exp_grant,
                         input logic [WIDTH-1:0] exp_num, input logic exp_prime, input int exp_lat,
                         input logic [NUM_REQ-1:0] valid_after);
    #1;
    check({name, "_grant"}, req_ready, exp_grant);
    tick();
    req_valid = valid_after;
    wait_rsp(name, exp_grant, exp_num, exp_prime, exp_lat);
  endtask

  logic [WIDTH-1:0] arb_num[4];
  logic             arb_prime[4];
  int               arb_lat[4];
  logic [NUM_REQ-1:0] any_rsp;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{num: 16'd2,     is_prime: 1'b1, lat: 2};
    vecs[1]  = '{num: 16'd1,     is_prime: 1'b0, lat: 2};
    vecs[2]  = '{num: 16'd0,     is_prime: 1'b0, lat: 2};
    vecs[3]  = '{num: 16'd3,     is_prime: 1'b1, lat: 2};
    vecs[4]  = '{num: 16'd4,     is_prime: 1'b0, lat: 2};
    vecs[5]  = '{num: 16'd25,    is_prime: 1'b0, lat: 3};
    vecs[6]  = '{num: 16'd97,    is_prime: 1'b1, lat: 4};
    vecs[7]  = '{num: 16'd49,    is_prime: 1'b0, lat: 3};
    vecs[8]  = '{num: 16'd121,   is_prime: 1'b0, lat: 4};
    vecs[9]  = '{num: 16'd113,   is_prime: 1'b1, lat: 4};
    vecs[10] = '{num: 16'd65521, is_prime: 1'b1, lat: 45};
    vecs[11] = '{num: 16'd65535, is_prime: 1'b0, lat: 2};

    arb_num[0] = 16'd2;  arb_prime[0] = 1'b1; arb_lat[0] = 2;
    arb_num[1] = 16'd25; arb_prime[1] = 1'b0; arb_lat[1] = 3;
    arb_num[2] = 16'd97; arb_prime[2] = 1'b1; arb_lat[2] = 4;
    arb_num[3] = 16'd4;  arb_prime[3] = 1'b0; arb_lat[3] = 2;

    // Reset with all requesters already valid.
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = '1;
    req_num   = '0;
    for (int i = 0; i < NUM_REQ; i++) set_num(i, arb_num[i]);
    tick();
    tick();
    #1;
    check("reset_ready",     req_ready,    0);
    check("reset_rsp_valid", rsp_valid,    0);
    check("reset_rsp_num",   rsp_num,      0);
    check("reset_is_prime",  rsp_is_prime, 0);
    check("reset_busy",      busy,         0);

    // Arbitration: grant order 0,1,2,3,0, then only 1 and 3 valid with rr_ptr=1.
    reset_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      run_one($sformatf("arb%0d", g), NUM_REQ'(1) << (g % 4), arb_num[g % 4],
              arb_prime[g % 4], arb_lat[g % 4], (g == 4) ? 4'b1010 : 4'b1111);
    end
    run_one("arb_rr1", 4'b0010, arb_num[1], arb_prime[1], arb_lat[1], 4'b0000);

    // Single-requester table.
    for (int i = 0; i < 12; i++) begin
      req_valid = 4'b0001;
      set_num(0, vecs[i].num);
      run_one($sformatf("vec%0d_n%0d", i, vecs[i].num), 4'b0001, vecs[i].num,
              vecs[i].is_prime, vecs[i].lat, 4'b0000);
    end

    // Flush at loop cycle 10 of 65521; pending req 2 granted in the following IDLE cycle.
    req_valid = 4'b0001;
    set_num(0, 16'd65521);
    set_num(2, 16'd97);
    #1;
    check("flush_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0100;
    any_rsp   = '0;
    for (int c = 1; c < 11; c++) begin
      #1;
      any_rsp |= rsp_valid;
      tick();
    end
    flush = 1'b1;
    #1;
    any_rsp |= rsp_valid;
    check("flush_busy_before", busy, 1);
    tick();
    flush = 1'b0;
    #1;
    any_rsp |= rsp_valid;
    check("flush_no_rsp", any_rsp, 0);
    check("flush_idle",   busy,    0);
    check("flush_regrant", req_ready, 4'b0100);
    run_one("flush_req2", 4'b0100, 16'd97, 1'b1, 4, 4'b0000);

    // Flush held in IDLE must not block a grant.
    flush     = 1'b1;
    req_valid = 4'b0001;
    set_num(0, 16'd3);
    #1;
    check("idle_flush_grant", req_ready, 4'b0001);
    tick();
    flush     = 1'b0;
    req_valid = 4'b0000;
    wait_rsp("idle_flush", 4'b0001, 16'd3, 1'b1, 2);

    // Reset during TEST: drops the test, outputs return to reset values.
    req_valid = 4'b0001;
    set_num(0, 16'd65521);
    #1;
    check("rst_mid_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    check("rst_mid_busy", busy, 1);
    reset_n   = 1'b0;
    req_valid = 4'b1100;
    set_num(2, 16'd49);
    set_num(3, 16'd2);
    tick();
    #1;
    check("rst_mid_ready",     req_ready,    0);
    check("rst_mid_rsp_valid", rsp_valid,    0);
    check("rst_mid_rsp_num",   rsp_num,      0);
    check("rst_mid_is_prime",  rsp_is_prime, 0);
    check("rst_mid_busy_low",  busy,         0);
    tick();
    reset_n = 1'b1;
    any_rsp = '0;
    run_one("rst_regrant", 4'b0100, 16'd49, 1'b0, 3, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
